// File: rtl/fix_burst.sv
// rtl/fix_burst.sv - constant-burst generator expanding each input token into LEN beats
module fix_burst #(
    parameter int DIN     = 1,
    parameter int TOUT    = 8,
    parameter int VAL     = 0,
    parameter int STEP    = 0,
    parameter int LEN     = 1,
    parameter int OUT_REG = 0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            din_ready,
    input  logic            din_valid,
    input  logic [DIN-1:0]  din_data,
    input  logic            dout_ready,
    output logic            dout_valid,
    output logic [TOUT:0]   dout_data
);

    localparam int            CW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    logic [CW-1:0]   cnt;
    logic [TOUT-1:0] gen_value;
    logic            gen_eot;
    logic [TOUT:0]   gen_beat;
    logic            gen_fire;

    // The token payload carries no information for this block; only its handshake matters.
    logic unused_din;
    assign unused_din = ^din_data;

    // Current beat: arithmetic is done in TOUT bits so the sequence wraps naturally.
    always_comb begin
        gen_value = TOUT'(VAL) + TOUT'(cnt) * TOUT'(STEP);
        gen_eot   = (cnt == LAST);
        gen_beat  = {gen_eot, gen_value};
    end

    // Beat counter: advances on every handed-on beat, wraps after the last beat of a burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (gen_fire) begin
            cnt <= gen_eot ? '0 : cnt + 1'b1;
        end
    end

    // The token is consumed only together with the final beat of its burst.
    assign din_ready = gen_fire & gen_eot;

    generate
        if (OUT_REG == 0) begin : g_comb
            assign gen_fire   = din_valid & dout_ready;
            assign dout_valid = din_valid;
            assign dout_data  = gen_beat;
        end else begin : g_reg
            logic          stage_valid;
            logic [TOUT:0] stage_data;
            logic          load;

            // A new beat may enter when the stage is empty or is draining this cycle.
            assign load     = din_valid & (~stage_valid | dout_ready);
            assign gen_fire = load;

            // Single output register stage; holds its beat under backpressure.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_valid <= 1'b0;
                    stage_data  <= '0;
                end else if (load) begin
                    stage_valid <= 1'b1;
                    stage_data  <= gen_beat;
                end else if (dout_ready & stage_valid) begin
                    stage_valid <= 1'b0;
                end
            end

            assign dout_valid = stage_valid;
            assign dout_data  = stage_data;
        end
    endgenerate

endmodule

// File: tb/tb_fix_burst.sv
// tb/tb_fix_burst.sv - self-checking bench for fix_burst over four parameter sets
module tb_fix_burst;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    logic din_valid;
    logic dout_ready;
    logic [0:0] din_data;

    logic       dv [N];
    logic       dr [N];
    logic [8:0] dd [N];

    logic [8:0] d0, d1, d3;
    logic [4:0] d2;
    logic       v0, v1, v2, v3;
    logic       r0, r1, r2, r3;

    always #5 clk = ~clk;

    fix_burst #(.DIN(1), .TOUT(8), .VAL(5), .STEP(3), .LEN(4), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .din_ready(r0), .din_valid(din_valid), .din_data(din_data),
        .dout_ready(dout_ready), .dout_valid(v0), .dout_data(d0));
    fix_burst #(.DIN(1), .TOUT(8), .VAL(5), .STEP(3), .LEN(4), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst), .din_ready(r1), .din_valid(din_valid), .din_data(din_data),
        .dout_ready(dout_ready), .dout_valid(v1), .dout_data(d1));
    fix_burst #(.DIN(1), .TOUT(4), .VAL(14), .STEP(1), .LEN(3), .OUT_REG(0)) u2 (
        .clk(clk), .rst(rst), .din_ready(r2), .din_valid(din_valid), .din_data(din_data),
        .dout_ready(dout_ready), .dout_valid(v2), .dout_data(d2));
    fix_burst #(.DIN(1), .TOUT(8), .VAL(170), .STEP(0), .LEN(1), .OUT_REG(1)) u3 (
        .clk(clk), .rst(rst), .din_ready(r3), .din_valid(din_valid), .din_data(din_data),
        .dout_ready(dout_ready), .dout_valid(v3), .dout_data(d3));

    assign dv[0] = v0; assign dv[1] = v1; assign dv[2] = v2; assign dv[3] = v3;
    assign dr[0] = r0; assign dr[1] = r1; assign dr[2] = r2; assign dr[3] = r3;
    assign dd[0] = d0; assign dd[1] = d1; assign dd[2] = {4'b0, d2}; assign dd[3] = d3;

    function automatic int p_tout(int i);
        return (i == 2) ? 4 : 8;
    endfunction
    function automatic int p_val(int i);
        case (i)
            2:       return 14;
            3:       return 170;
            default: return 5;
        endcase
    endfunction
    function automatic int p_step(int i);
        case (i)
            2:       return 1;
            3:       return 0;
            default: return 3;
        endcase
    endfunction
    function automatic int p_len(int i);
        case (i)
            2:       return 3;
            3:       return 1;
            default: return 4;
        endcase
    endfunction
    function automatic bit p_oreg(int i);
        return (i == 1) || (i == 3);
    endfunction

    // Beat k of the endless stream: position within its burst decides value and eot.
    function automatic bit m_eot(int i, int k);
        return (k % p_len(i)) == (p_len(i) - 1);
    endfunction
    function automatic logic [8:0] m_beat(int i, int k);
        int         pos;
        int         v;
        logic [8:0] r;
        pos = k % p_len(i);
        v   = (p_val(i) + pos * p_step(i)) % (1 << p_tout(i));
        r   = 9'(v);
        r[p_tout(i)] = m_eot(i, k);
        return r;
    endfunction

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input int i, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s u%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
        end
    endtask

    // Model state: beats delivered since reset, and whether the output stage should be full.
    int   k     [N];
    logic sv    [N];
    bit   model_ok = 1'b0;

    bit         rec = 1'b0;
    logic [8:0] q0[$], q1[$], q2[$];
    int         qc1[$];
    int         nrdy [N];
    int         nhs  [N];
    int         vstart = 0;
    logic       vprev = 1'b0;
    logic       rprev = 1'b0;
    logic       post_rst_v1 = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (din_valid && !vprev) vstart = cyc;
        if (!rst && rprev) post_rst_v1 = v1;
        for (int i = 0; i < N; i++) begin
            logic ev;
            logic erdy;
            ev = p_oreg(i) ? sv[i] : din_valid;
            if (rst) begin
                k[i]  = 0;
                sv[i] = 1'b0;
            end else if (model_ok) begin
                if (p_oreg(i))
                    erdy = din_valid & (!ev | dout_ready) & m_eot(i, k[i] + int'(ev));
                else
                    erdy = din_valid & dout_ready & m_eot(i, k[i]);
                chk("dout_valid", i, 9'(dv[i]), 9'(ev));
                chk("din_ready", i, 9'(dr[i]), 9'(erdy));
                if (ev) chk("dout_data", i, dd[i], m_beat(i, k[i]));
                if (dr[i]) nrdy[i]++;
                if (dv[i] && dout_ready) nhs[i]++;
                if (rec && dv[i] && dout_ready) begin
                    if (i == 0) q0.push_back(dd[i]);
                    if (i == 1) begin q1.push_back(dd[i]); qc1.push_back(cyc); end
                    if (i == 2) q2.push_back(dd[i]);
                end
                if (p_oreg(i)) sv[i] = din_valid | (ev & !dout_ready);
                if (ev && dout_ready) k[i]++;
            end
        end
        if (rst) model_ok = 1'b1;
        vprev = din_valid;
        rprev = rst;
    end

    task automatic clear_rec();
        q0.delete(); q1.delete(); q2.delete(); qc1.delete();
        for (int i = 0; i < N; i++) begin nrdy[i] = 0; nhs[i] = 0; end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] exp_a [4];
        logic [8:0] exp_w [4];
        rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; din_data = 1'b1;
        clear_rec();
        cycles(3);
        rst = 1'b0;

        // One token, full throughput
        clear_rec(); rec = 1'b1;
        din_valid = 1'b1; dout_ready = 1'b1;
        cycles(4);
        din_valid = 1'b0;
        cycles(3);
        exp_a = '{9'h005, 9'h008, 9'h00B, 9'h10E};
        exp_w = '{9'h00E, 9'h00F, 9'h010, 9'h00E};
        chk("u0_beats_n", 0, 9'(q0.size()), 9'd4);
        chk("u1_beats_n", 1, 9'(q1.size()), 9'd4);
        chk("u2_beats_n", 2, 9'(q2.size()), 9'd4);
        for (int j = 0; j < 4; j++) begin
            chk("u0_seq", 0, (q0.size() > j) ? q0[j] : 9'h1FF, exp_a[j]);
            chk("u1_seq", 1, (q1.size() > j) ? q1[j] : 9'h1FF, exp_a[j]);
            chk("u2_wrap", 2, (q2.size() > j) ? q2[j] : 9'h1FF, exp_w[j]);
        end
        chk("u0_rdy_pulses", 0, 9'(nrdy[0]), 9'd1);
        chk("u1_rdy_pulses", 1, 9'(nrdy[1]), 9'd1);
        chk("model_pin_len1", 3, m_beat(3, 7), 9'h1AA);

        // Two tokens back-to-back through the registered variant
        clear_rec();
        din_valid = 1'b1;
        cycles(8);
        din_valid = 1'b0;
        cycles(3);
        chk("u1_b2b_n", 1, 9'(q1.size()), 9'd8);
        for (int j = 0; j < 8; j++) begin
            chk("u1_b2b_seq", 1, (q1.size() > j) ? q1[j] : 9'h1FF, exp_a[j % 4]);
            chk("u1_b2b_cyc", 1, 9'((qc1.size() > j) ? qc1[j] - vstart : 0), 9'(j + 1));
        end
        chk("u0_b2b_rdy", 0, 9'(nrdy[0]), 9'd2);
        chk("u1_b2b_rdy", 1, 9'(nrdy[1]), 9'd2);

        // Random backpressure with occasional upstream gaps
        clear_rec();
        for (int n = 0; n < 300; n++) begin
            dout_ready = 1'($urandom_range(0, 1));
            din_valid  = ($urandom_range(0, 9) != 0);
            cycles(1);
        end
        din_valid = 1'b0; dout_ready = 1'b1;
        cycles(4);
        chk("u3_rdy_eq_hs", 3, 9'(nrdy[3]), 9'(nhs[3]));

        // Reset in the middle of a burst
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        din_valid = 1'b1; dout_ready = 1'b1;
        cycles(3);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        clear_rec();
        cycles(5);
        din_valid = 1'b0;
        cycles(3);
        chk("u1_empty_after_rst", 1, 9'(post_rst_v1), 9'd0);
        chk("u0_restart", 0, (q0.size() > 0) ? q0[0] : 9'h1FF, 9'h005);
        chk("u1_restart", 1, (q1.size() > 0) ? q1[0] : 9'h1FF, 9'h005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
